// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: rx synchroniser, start-bit validation, LSB-first deserialiser,
// and a small circular byte FIFO presented to the consumer over valid/ready.
//
// state       | meaning
// S_IDLE      | line idle, waiting for rx_s low
// S_START     | timing to mid start bit, rejects glitches
// S_DATA      | sampling 8 data bits, LSB first
// S_STOP      | sampling stop bit: commit byte or flag framing error
// S_WAIT_HIGH | framing error seen, holding off until the line returns high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 723,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        rx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_data,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        frame_err,
    output logic                        overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] DEPTH   = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic          rx_m_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          commit, pop, push, full;

    // Down-counter reloaded on every state change; a sample is taken at terminal count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        commit      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_M1;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = BIT_M1;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_M1;
                    if (rx_s_q) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                    cnt_d   = BIT_M1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        full      = (count_q == DEPTH);
        pop       = (count_q != '0) && out_ready;
        push      = commit && (!full || pop);
        overrun_d = commit && !push;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
        // Head is re-registered each cycle; bypass when the new head is the byte being written.
        out_data_d = out_data_q;
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = shift_q;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
        end else begin
            rx_m_q      <= rx;
            rx_s_q      <= rx_m_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_data_q;
    assign level     = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive front-end feeding the core's serial input path. Receives the board-level rx pin.
- Synchronises rx, detects and validates start bits, and deserialises 8N1 frames LSB-first.
- Queues received bytes in a small FIFO and presents them to the downstream consumer over a valid/ready interface.
- Flags framing errors and FIFO overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 723, clock cycles per bit (83.33 MHz / 115200). Must be ≥ 4.
- FIFO_DEPTH, 8, byte entries. Power of two, ≥ 2.

Ports:
- CLK  input  1  system clock (PLL output).
- RST_N  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line, asynchronous, idle high.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head byte.
- out_data  output  8  FIFO head byte.
- level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: byte dropped because FIFO full.

Behaviour:
- Reset (RST_N low, asynchronous assert): both synchroniser flops load 1; FSM goes to IDLE; counters, shift register and FIFO pointers clear.
  - Outputs during reset: out_valid=0, level=0, frame_err=0, overrun=0, out_data=0.
  - Deassertion is taken synchronously. Any frame in flight at reset is lost.
- Synchroniser: 2-flop chain. Define rx_s as the second flop's output. All decisions use rx_s only.
- Timing: one bit counter, reloaded at every state transition. Define HALF = CLKS_PER_BIT/2 (integer division).
- FSM states:
  - IDLE: if rx_s==0, go to START with counter cleared.
  - START: after HALF cycles, sample rx_s.
    - 1: glitch. Return to IDLE; no error is flagged.
    - 0: go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[index] (LSB first). After index 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: commit the byte, go to IDLE.
    - 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This blocks retriggering while the line is held low (break).
- Sampling position: start bit sampled at mid-bit; data and stop bits sampled at mid-bit ±1 cycle. There is no re-sync inside a frame.
- Commit rules:
  - Push if FIFO not full, or if full and a pop occurs in the same cycle.
  - Otherwise pulse overrun and drop the new byte; FIFO contents are unchanged.
  - frame_err and overrun are never asserted in the same cycle.
- Latency: out_valid rises the cycle after the commit cycle, when the FIFO was empty. From the first cycle rx_s==0, that is HALF + 9·CLKS_PER_BIT + 1 cycles, ±1.
- FIFO: registered, circular, with wrap-around read/write pointers.
  - Pop occurs when out_valid && out_ready.
  - out_data is the registered head entry. It is valid only while out_valid=1; otherwise it holds its last value.
  - Push and pop in the same cycle leave level unchanged.
  - Pop from empty is ignored. out_ready is allowed high at any time.
  - level never exceeds FIFO_DEPTH.
- Ordering: bytes leave in arrival order. No byte is duplicated.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=8.
1. Single byte: drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) with out_ready=0 → out_valid=1, out_data=0xA5, level=1 about 153 cycles after the falling edge. Then pulse out_ready for 1 cycle → out_valid=0, level=0.
2. Glitch and break:
   - rx low for 5 cycles → no state advance, no frame_err, level=0.
   - Frame 0x3C with stop bit 0, then rx held low for 64 cycles, then high → exactly one frame_err pulse, level=0. A following valid 0x81 frame is received correctly.
3. Overrun: 9 back-to-back frames 0x00..0x08 with out_ready=0 → level=8, one overrun pulse at the 9th stop sample. Draining yields 0x00..0x07 in order, then out_valid=0.
4. Full with simultaneous pop: fill with 8 bytes, then send 0x55 with out_ready=1 held exactly in its commit cycle → no overrun, level stays 8, and 0x55 is the last byte drained.
5. Continuous streaming: 32 random bytes with out_ready=1 always → all 32 received in order, level ≤ 1, no error pulses, pointers wrap correctly.
6. Reset mid-operation: assert RST_N=0 during the DATA state of a frame with 3 bytes queued → outputs go to reset values immediately (asynchronously). After release with rx=1, the next clean frame 0xF0 is received as the only FIFO entry.
